brcomp_iter: RTL

BRCOMP_ITER -- requirements
Module: brcomp_iter

---
 rtl/brcomp_iter_if.sv | 24 ++
 rtl/brcomp_iter.sv | 114 +++++++++++
 2 files changed

// File: rtl/brcomp_iter_if.sv
// Handshake and operand bundle for the iterative branch comparator.
interface brcomp_iter_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic             br_unsigned;
    logic             out_valid;
    logic             out_ready;
    logic             br_less;
    logic             br_equal;

    modport master (
        output in_valid, rs1_data, rs2_data, br_unsigned, out_ready,
        input  in_ready, out_valid, br_less, br_equal
    );

    modport slave (
        input  in_valid, rs1_data, rs2_data, br_unsigned, out_ready,
        output in_ready, out_valid, br_less, br_equal
    );
endinterface

// File: rtl/brcomp_iter.sv
// Iterative branch comparator: CHUNK bits per cycle, MSB chunk first.
// Optional macro BRCOMP_ITER_EARLY_EXIT_EN finishes on the first differing chunk.
module brcomp_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    brcomp_iter_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [IDXW-1:0]  TOP_IDX  = IDXW'(NCHUNK - 1);

    logic [1:0]       r_state;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_rs1;
    logic [WIDTH-1:0] r_rs2;
    logic             r_found;
    logic             r_less;
    logic             r_equal;

    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic             w_first_diff;
    logic             w_last;
    logic             w_exit;
    logic [WIDTH-1:0] w_flip;

    // Current chunk selection and per-cycle decisions
    always_comb begin
        w_base       = 32'(r_idx) * 32'(CHUNK);
        w_a          = r_rs1[w_base +: CHUNK];
        w_b          = r_rs2[w_base +: CHUNK];
        w_first_diff = (w_a != w_b) && !r_found;
        w_last       = (r_idx == {IDXW{1'b0}});
        w_flip       = bus.br_unsigned ? {WIDTH{1'b0}} : MSB_MASK;
`ifdef BRCOMP_ITER_EARLY_EXIT_EN
        w_exit       = w_first_diff || w_last;
`else
        w_exit       = w_last;
`endif
    end

    // Control FSM, operand capture and sticky first-difference result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= {IDXW{1'b0}};
            r_rs1   <= {WIDTH{1'b0}};
            r_rs2   <= {WIDTH{1'b0}};
            r_found <= 1'b0;
            r_less  <= 1'b0;
            r_equal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Flipping the sign bit maps two's-complement order onto unsigned order.
                        r_rs1   <= bus.rs1_data ^ w_flip;
                        r_rs2   <= bus.rs2_data ^ w_flip;
                        r_idx   <= TOP_IDX;
                        r_found <= 1'b0;
                        r_less  <= 1'b0;
                        r_equal <= 1'b0;
                        r_state <= CMP;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CMP: begin
                    if (w_first_diff) begin
                        r_found <= 1'b1;
                        r_less  <= (w_a < w_b);
                        r_equal <= 1'b0;
                    end else if (w_last && !r_found) begin
                        r_less  <= 1'b0;
                        r_equal <= 1'b1;
                    end else begin
                        r_found <= r_found;
                    end
                    if (w_exit) begin
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx - IDXW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE) && !rst;
    assign bus.out_valid = (r_state == DONE) && !rst;
    assign bus.br_less   = r_less  && !rst;
    assign bus.br_equal  = r_equal && !rst;

endmodule
